// File: rtl/idma_be_arbiter.sv
// idma_be_arbiter: round-robin share of one iDMA backend.
// Tracks outstanding transfers and routes completions back.
module idma_be_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned ReqWidth       = 192,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic [NumReq*ReqWidth-1:0] req_data_i,
  output logic                       be_valid_o,
  input  logic                       be_ready_i,
  output logic [ReqWidth-1:0]        be_req_o,
  input  logic                       be_done_i,
  output logic [NumReq-1:0]          done_o,
  input  logic                       flush_i,
  input  logic [NumReq-1:0]          irq_clr_i,
  output logic [NumReq-1:0]          irq_o,
  output logic                       idle_o,
  output logic                       err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic                be_valid_q;
  logic [ReqWidth-1:0] be_req_q;
  logic [IdxW-1:0]     owner_q;
  logic [IdxW-1:0]     last_q;
  logic [IdxW-1:0]     fifo_q [MaxOutstanding];
  logic [PtrW-1:0]     wptr_q;
  logic [PtrW-1:0]     rptr_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     cnt_d;
  logic [NumReq-1:0]   irq_q;
  logic                err_q;

  logic [ReqWidth-1:0] req_data [NumReq];
  logic                gnt_found;
  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_en;
  logic                push;
  logic                pop;
  logic [IdxW-1:0]     head;
  int unsigned         rr_j;

  for (genvar i = 0; i < NumReq; i++) begin : g_slice
    assign req_data[i] = req_data_i[i*ReqWidth +: ReqWidth];
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_j      = 0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      rr_j = 32'(last_q) + k;
      if (rr_j >= NumReq) rr_j = rr_j - NumReq;
      if (!gnt_found && req_valid_i[rr_j[IdxW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_j[IdxW-1:0];
      end
    end
  end

  assign gnt_en = !rst_i && (state_q == IDLE) && !flush_i &&
                  (cnt_q < CntW'(MaxOutstanding)) && gnt_found;

  assign push  = !rst_i && (state_q == OFFER) && be_ready_i;
  assign pop   = !rst_i && be_done_i && (cnt_q != '0);
  assign head  = fifo_q[rptr_q];
  assign cnt_d = cnt_q + CntW'(push) - CntW'(pop);

  // One-hot accept toward the round-robin winner.
  always_comb begin
    req_ready_o = '0;
    if (gnt_en) req_ready_o[gnt_idx] = 1'b1;
  end

  // Completion pulse routed to the oldest outstanding owner.
  always_comb begin
    done_o = '0;
    if (pop) done_o[head] = 1'b1;
  end

  // Grant / offer / drain control with registered payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      be_valid_q <= 1'b0;
      be_req_q   <= '0;
      owner_q    <= '0;
      last_q     <= IdxW'(NumReq - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush_i) begin
            state_q <= DRAIN;
          end else if (gnt_en) begin
            state_q    <= OFFER;
            be_valid_q <= 1'b1;
            be_req_q   <= req_data[gnt_idx];
            owner_q    <= gnt_idx;
            last_q     <= gnt_idx;
          end
        end
        OFFER: begin
          if (be_ready_i) begin
            be_valid_q <= 1'b0;
            state_q    <= flush_i ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (cnt_d == '0 && !flush_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Owner ID storage; contents are qualified by the count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= owner_q;
  end

  // Pointers and outstanding count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Sticky interrupt (set beats clear) and orphan-completion error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= '0;
      err_q <= 1'b0;
    end else begin
      irq_q <= (irq_q & ~irq_clr_i) | done_o;
      if (be_done_i && cnt_q == '0) err_q <= 1'b1;
    end
  end

  assign be_valid_o = be_valid_q & ~rst_i;
  assign be_req_o   = be_req_q;
  assign irq_o      = irq_q;
  assign err_o      = err_q;
  assign idle_o     = (state_q == IDLE) && (cnt_q == '0) &&
                      !be_valid_q;

endmodule

// File: tb/tb_idma_be_arbiter.sv
// tb_idma_be_arbiter: vector table, directed corners and
// random traffic against a transaction-level model.
module tb_idma_be_arbiter;

  localparam int N = 4;
  localparam int W = 192;
  localparam int M = 4;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_data_i;
  logic           be_valid_o;
  logic           be_ready_i;
  logic [W-1:0]   be_req_o;
  logic           be_done_i;
  logic [N-1:0]   done_o;
  logic           flush_i;
  logic [N-1:0]   irq_clr_i;
  logic [N-1:0]   irq_o;
  logic           idle_o;
  logic           err_o;

  idma_be_arbiter #(
    .NumReq(N), .ReqWidth(W), .MaxOutstanding(M)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i),
    .be_valid_o(be_valid_o), .be_ready_i(be_ready_i),
    .be_req_o(be_req_o), .be_done_i(be_done_i),
    .done_o(done_o), .flush_i(flush_i),
    .irq_clr_i(irq_clr_i), .irq_o(irq_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: held offer, drain mode, queue of owners.
  bit           m_hold;
  bit           m_fl;
  int           m_owner;
  int           m_last;
  logic [W-1:0] m_pay;
  int           q[$];
  logic [N-1:0] m_irq;
  logic         m_err;

  // Values sampled in the last cycle.
  int           s_g;
  logic [N-1:0] s_rdy, s_done, s_irq;
  logic         s_bv, s_idle, s_err;
  logic [W-1:0] s_req;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int i);
    return {(W/32){32'(i + 1) * 32'h0101_0101}};
  endfunction

  task automatic set_pat();
    for (int i = 0; i < N; i++) req_data_i[i*W +: W] = pat(i);
  endtask

  task automatic rnd_data();
    for (int i = 0; i < N*W/32; i++)
      req_data_i[i*32 +: 32] = $urandom();
  endtask

  task automatic mreset();
    m_hold = 0; m_fl = 0; m_owner = 0; m_last = N - 1;
    m_pay = '0; q.delete(); m_irq = '0; m_err = 1'b0;
  endtask

  function automatic int winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic cyc(input logic r, input logic [N-1:0] v,
                     input logic rdy, input logic dn,
                     input logic fl, input logic [N-1:0] clr);
    int eg;
    logic [N-1:0] er, ed;
    logic ebv, eid;
    bit was_hold, was_fl;
    rst_i = r; req_valid_i = v; be_ready_i = rdy;
    be_done_i = dn; flush_i = fl; irq_clr_i = clr;
    eg = (!r && !m_hold && !m_fl && !fl && q.size() < M)
         ? winner(v) : -1;
    er = (eg >= 0) ? N'(1) << eg : '0;
    ed = (!r && dn && q.size() > 0) ? N'(1) << q[0] : '0;
    ebv = !r && m_hold;
    eid = !m_hold && !m_fl && q.size() == 0;
    @(negedge clk);
    s_g = -1;
    for (int i = 0; i < N; i++) if (req_ready_o[i] === 1'b1) s_g = i;
    s_rdy = req_ready_o; s_done = done_o; s_irq = irq_o;
    s_bv = be_valid_o; s_idle = idle_o; s_err = err_o;
    s_req = be_req_o;
    chk("ready", W'(req_ready_o), W'(er));
    chk("done", W'(done_o), W'(ed));
    chk("be_valid", W'(be_valid_o), W'(ebv));
    chk("be_req", be_req_o, m_pay);
    chk("idle", W'(idle_o), W'(eid));
    chk("irq", W'(irq_o), W'(m_irq));
    chk("err", W'(err_o), W'(m_err));
    @(posedge clk);
    if (r) begin
      mreset();
    end else begin
      was_hold = m_hold; was_fl = m_fl;
      if (dn && q.size() > 0) begin
        int h;
        h = q.pop_front();
        m_irq = m_irq & ~clr;
        m_irq[h] = 1'b1;
      end else begin
        m_irq = m_irq & ~clr;
        if (dn) m_err = 1'b1;
      end
      if (was_hold && rdy) begin
        q.push_back(m_owner);
        m_hold = 0;
        if (fl) m_fl = 1;
      end
      if (eg >= 0) begin
        m_hold = 1; m_owner = eg; m_last = eg;
        m_pay = req_data_i[eg*W +: W];
      end
      if (!was_hold && !was_fl && fl) m_fl = 1;
      if (was_fl && q.size() == 0 && !fl) m_fl = 0;
    end
    #1;
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] v;
    logic         rdy;
    logic         dn;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_done;
    logic         e_bv;
    logic         e_idle;
    int           e_pay;
  } vec_t;

  vec_t tv[8];

  initial begin
    rst_i = 1'b1; req_valid_i = '0; be_ready_i = 1'b0;
    be_done_i = 1'b0; flush_i = 1'b0; irq_clr_i = '0;
    set_pat();
    @(posedge clk); #1;
    mreset();

    // Two requesters at once: grants 0 then 2, completions in order.
    tv[0] = '{1'b1, 4'b0101, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, -1};
    tv[1] = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, -1};
    tv[2] = '{1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 0};
    tv[3] = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, -1};
    tv[4] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2};
    tv[5] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, -1};
    tv[6] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, -1};
    tv[7] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, -1};
    for (int i = 0; i < 8; i++) begin
      cyc(tv[i].r, tv[i].v, tv[i].rdy, tv[i].dn, 1'b0, '0);
      chk("tv_ready", W'(s_rdy), W'(tv[i].e_rdy));
      chk("tv_done", W'(s_done), W'(tv[i].e_done));
      chk("tv_valid", W'(s_bv), W'(tv[i].e_bv));
      chk("tv_idle", W'(s_idle), W'(tv[i].e_idle));
      if (tv[i].e_pay >= 0) chk("tv_req", s_req, pat(tv[i].e_pay));
    end

    // All valid: four grants fill the window, then wait for a done.
    begin
      int gl[$];
      int ng;
      cyc(1, '0, 0, 0, 0, '0);
      for (int c = 0; c < 12; c++) begin
        cyc(0, 4'hF, 1, 0, 0, '0);
        if (s_g >= 0) gl.push_back(s_g);
      end
      chk("rr_count", W'(gl.size()), W'(4));
      for (int i = 0; i < 4; i++)
        if (i < gl.size()) chk("rr_order", W'(gl[i]), W'(i));
      cyc(0, 4'hF, 1, 1, 0, '0);
      chk("rr_full", W'(s_rdy), W'(0));
      ng = -1;
      for (int c = 0; c < 4 && ng < 0; c++) begin
        cyc(0, 4'hF, 1, 0, 0, '0);
        ng = s_g;
      end
      chk("rr_next", W'(ng), W'(0));
    end

    // Backpressure: offer and payload hold while inputs churn.
    cyc(1, '0, 0, 0, 0, '0);
    set_pat();
    cyc(0, 4'b0010, 0, 0, 0, '0);
    for (int c = 0; c < 5; c++) begin
      rnd_data();
      cyc(0, 4'hF, 0, 0, 0, '0);
      chk("hold_valid", W'(s_bv), W'(1));
      chk("hold_req", s_req, pat(1));
      chk("hold_ready", W'(s_rdy), W'(0));
    end
    cyc(0, '0, 1, 0, 0, '0);

    // Flush with three transfers outstanding.
    cyc(1, '0, 0, 0, 0, '0);
    for (int c = 0; c < 6; c++) cyc(0, 4'hF, 1, 0, 0, '0);
    for (int c = 0; c < 3; c++) begin
      cyc(0, 4'hF, 1, 0, 1, '0);
      chk("flush_nogrant", W'(s_rdy), W'(0));
    end
    for (int c = 0; c < 2; c++) begin
      cyc(0, 4'hF, 1, 1, 1, '0);
      chk("flush_nogrant", W'(s_rdy), W'(0));
    end
    cyc(0, 4'hF, 1, 0, 0, '0);
    chk("drain_nogrant", W'(s_rdy), W'(0));
    cyc(0, 4'hF, 1, 1, 0, '0);
    chk("drain_idle", W'(s_idle), W'(0));
    cyc(0, 4'hF, 1, 0, 0, '0);
    chk("drain_done_idle", W'(s_idle), W'(1));
    chk("resume_grant", W'(s_rdy), W'(4'b1000));

    // Orphan completion and irq set-beats-clear.
    cyc(1, '0, 0, 0, 0, '0);
    cyc(0, '0, 0, 1, 0, '0);
    cyc(0, '0, 0, 0, 0, '0);
    chk("err_set", W'(s_err), W'(1));
    cyc(0, 4'b0010, 1, 0, 0, '0);
    cyc(0, '0, 1, 0, 0, '0);
    cyc(0, '0, 0, 1, 0, 4'b0010);
    chk("done_r1", W'(s_done), W'(4'b0010));
    cyc(0, '0, 0, 0, 0, 4'b0010);
    chk("irq_set_wins", W'(s_irq[1]), W'(1));
    cyc(0, '0, 0, 0, 0, '0);
    chk("irq_cleared", W'(s_irq[1]), W'(0));

    // Reset mid-offer with two transfers outstanding.
    cyc(1, '0, 0, 0, 0, '0);
    for (int c = 0; c < 5; c++) cyc(0, 4'hF, 1, 0, 0, '0);
    cyc(0, 4'hF, 0, 0, 0, '0);
    chk("pre_rst_valid", W'(s_bv), W'(1));
    cyc(1, 4'hF, 0, 0, 0, '0);
    cyc(0, '0, 0, 0, 0, '0);
    chk("post_rst_valid", W'(s_bv), W'(0));
    chk("post_rst_idle", W'(s_idle), W'(1));
    cyc(0, '0, 0, 1, 0, '0);
    cyc(0, '0, 0, 0, 0, '0);
    chk("post_rst_err", W'(s_err), W'(1));

    // Random traffic against the model.
    begin
      logic fl;
      logic [N-1:0] clr;
      fl = 1'b0;
      cyc(1, '0, 0, 0, 0, '0);
      for (int c = 0; c < 3000; c++) begin
        rnd_data();
        if ($urandom_range(0, 19) == 0) fl = ~fl;
        clr = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '0;
        cyc($urandom_range(0, 199) == 0, N'($urandom()),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, fl, clr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
